// File: rtl/shared_adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : shared_adder_arbiter_if
// Purpose  : Requester and result handshake bundle for shared_adder_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface shared_adder_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 6,
    parameter int SRC_WIDTH = $clog2(N_REQ)
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*WIDTH-1:0]     req_a;
    logic [N_REQ*WIDTH-1:0]     req_b;
    logic [N_REQ*TAG_WIDTH-1:0] req_tag;
    logic                       res_valid;
    logic                       res_ready;
    logic [WIDTH-1:0]           res_sum;
    logic [TAG_WIDTH-1:0]       res_tag;
    logic [SRC_WIDTH-1:0]       res_src;

    // Requesters and result consumer side
    modport master (
        output req_valid, req_a, req_b, req_tag, res_ready,
        input  req_ready, res_valid, res_sum, res_tag, res_src
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_tag, res_ready,
        output req_ready, res_valid, res_sum, res_tag, res_src
    );
endinterface
`default_nettype wire

// File: rtl/shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_adder_arbiter
// Purpose  : Round-robin sharing of one ripple-carry adder among N_REQ
//            requesters; registered result with tag and source index.
//            Optional macro SHARED_ADDER_ARB_PERF_EN adds perf_conflict_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module shared_adder_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 6,
    parameter int SRC_WIDTH = $clog2(N_REQ)
) (
    input  wire logic              clk,
    input  wire logic              rst_aL,
    input  wire logic              flush,
    shared_adder_arbiter_if.slave  bus
`ifdef SHARED_ADDER_ARB_PERF_EN
    ,
    output logic [31:0]            perf_conflict_cnt
`endif
);

    localparam logic [SRC_WIDTH:0]   c_n_req_ext = (SRC_WIDTH+1)'(N_REQ);
    localparam logic [SRC_WIDTH-1:0] c_last_idx  = SRC_WIDTH'(N_REQ - 1);

    logic                  r_res_valid;
    logic [WIDTH-1:0]      r_res_sum;
    logic [TAG_WIDTH-1:0]  r_res_tag;
    logic [SRC_WIDTH-1:0]  r_res_src;
    logic [SRC_WIDTH-1:0]  r_rr_ptr;

    logic                  w_grant_en;
    logic                  w_found;
    logic [SRC_WIDTH-1:0]  w_gidx;
    logic [SRC_WIDTH:0]    w_scan_idx;
    logic [N_REQ-1:0]      w_grant;
    logic [SRC_WIDTH-1:0]  w_ptr_next;
    logic [WIDTH-1:0]      w_op_a;
    logic [WIDTH-1:0]      w_op_b;
    logic [WIDTH-1:0]      w_sum;
    logic [WIDTH-1:0]      w_carry;

    // Reset is folded in so the grant is silent while rst_aL is held low.
    assign w_grant_en = rst_aL && !flush && (!r_res_valid || bus.res_ready);

    always_comb begin
        w_found    = 1'b0;
        w_gidx     = '0;
        w_scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_idx = {1'b0, r_rr_ptr} + (SRC_WIDTH+1)'(k);
            if (w_scan_idx >= c_n_req_ext) begin
                w_scan_idx = w_scan_idx - c_n_req_ext;
            end
            if (!w_found && bus.req_valid[w_scan_idx[SRC_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_scan_idx[SRC_WIDTH-1:0];
            end
        end
        if (!w_grant_en) begin
            w_found = 1'b0;
        end
    end

    assign w_grant    = w_found ? (N_REQ'(1) << w_gidx) : '0;
    assign w_ptr_next = (w_gidx == c_last_idx) ? '0 : w_gidx + SRC_WIDTH'(1);

    // Operand mux feeds the single adder instance
    assign w_op_a = bus.req_a[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_op_b = bus.req_b[int'(w_gidx)*WIDTH +: WIDTH];

    // Ripple-carry chain; the final carry-out is never formed so the sum wraps.
    assign w_carry[0] = 1'b0;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
        assign w_sum[gi] = w_op_a[gi] ^ w_op_b[gi] ^ w_carry[gi];
        if (gi < WIDTH - 1) begin : g_carry
            assign w_carry[gi+1] = (w_op_a[gi] & w_op_b[gi]) |
                                   (w_carry[gi] & (w_op_a[gi] ^ w_op_b[gi]));
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_tag   <= '0;
            r_res_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (flush) begin
            r_res_valid <= 1'b0;
        end else if (w_found) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= w_sum;
            r_res_tag   <= bus.req_tag[int'(w_gidx)*TAG_WIDTH +: TAG_WIDTH];
            r_res_src   <= w_gidx;
            r_rr_ptr    <= w_ptr_next;
        end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef SHARED_ADDER_ARB_PERF_EN
    logic [31:0] r_perf_cnt;
    logic        w_multi_valid;

    // Clearing the lowest set bit leaves a non-zero vector iff two or more bits were set.
    assign w_multi_valid = |(bus.req_valid & (bus.req_valid - N_REQ'(1)));

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_perf_cnt <= '0;
        end else if (w_found && w_multi_valid && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_conflict_cnt = r_perf_cnt;
`endif

    assign bus.req_ready = w_grant;
    assign bus.res_valid = r_res_valid;
    assign bus.res_sum   = r_res_sum;
    assign bus.res_tag   = r_res_tag;
    assign bus.res_src   = r_res_src;

endmodule
`default_nettype wire

// File: tb/tb_shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_adder_arbiter
// Purpose  : Self-checking bench for shared_adder_arbiter against a
//            transaction-level round-robin/adder reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_adder_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int T = 6;
    localparam int S = 2;

    logic clk;
    logic rst_aL;
    logic flush;

    shared_adder_arbiter_if #(.N_REQ(N), .WIDTH(W), .TAG_WIDTH(T), .SRC_WIDTH(S)) bus ();

`ifdef SHARED_ADDER_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
`endif

    shared_adder_arbiter #(.N_REQ(N), .WIDTH(W), .TAG_WIDTH(T), .SRC_WIDTH(S)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .flush  (flush),
        .bus    (bus)
`ifdef SHARED_ADDER_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state after the most recent edge
    int            m_ptr;
    logic          m_valid;
    logic [W-1:0]  m_sum;
    logic [T-1:0]  m_tag;
    logic [S-1:0]  m_src;
    longint        m_perf;

    logic [N-1:0]  obs_ready;
    logic [N-1:0]  exp_ready;

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_tag = '0; m_src = '0; m_perf = 0;
    endtask

    // Drive one cycle at posedge+1, sample req_ready at negedge, advance model,
    // and return at the next posedge+1 with registered outputs settled.
    task automatic tick(input logic [N-1:0] v, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input logic [N*T-1:0] tg,
                        input logic rr, input logic fl);
        int g;
        bus.req_valid = v; bus.req_a = a; bus.req_b = b; bus.req_tag = tg;
        bus.res_ready = rr; flush = fl;
        @(negedge clk);
        obs_ready = bus.req_ready;
        exp_ready = '0;
        g = -1;
        if ((!m_valid || rr) && !fl) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            m_sum   = a[g*W +: W] + b[g*W +: W];
            m_tag   = tg[g*T +: T];
            m_src   = S'(g);
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
            if ($countones(v) >= 2 && m_perf < 64'hFFFF_FFFF) m_perf++;
        end else if (fl || rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_aL = 1'b0; flush = 1'b0;
        bus.req_valid = '1; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        bus.res_ready = 1'b1;
        model_reset();
        #12;
        n_checks++;
        if (bus.req_ready !== '0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
        end
        n_checks++;
        if ({bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src} !== '0) begin
            n_fail++; $display("FAIL reset_result: got v=%b sum=%h tag=%h src=%0d want all zero",
                               bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src);
        end
`ifdef SHARED_ADDER_ARB_PERF_EN
        n_checks++;
        if (perf_conflict_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_perf: got %0d want 0", perf_conflict_cnt);
        end
`endif
        bus.req_valid = '0;
        @(negedge clk); rst_aL = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [N*W-1:0] a, b;
        logic [N*T-1:0] tg;
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < N; r++) begin
                a[r*W +: W] = $urandom; b[r*W +: W] = $urandom; tg[r*T +: T] = T'($urandom);
            end
            tick(4'b1111, a, b, tg, 1'b1, 1'b0);
            n_checks++;
            if (obs_ready !== exp_ready || obs_ready !== (N'(1) << (i % N))) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, obs_ready, N'(1) << (i % N));
            end
            n_checks++;
            if ({bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src} !== {m_valid, m_sum, m_tag, m_src}
                || bus.res_src !== S'(i % N)) begin
                n_fail++; $display("FAIL rr_result[%0d]: got v=%b sum=%h tag=%h src=%0d want v=%b sum=%h tag=%h src=%0d",
                                   i, bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src, m_valid, m_sum, m_tag, m_src);
            end
        end
        // Pointer is back at 0: the next contended grant goes to requester 0
        tick(4'b1111, a, b, tg, 1'b1, 1'b0);
        n_checks++;
        if (obs_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rr_ptr_back: got %b want 0001", obs_ready);
        end
        tick('0, a, b, tg, 1'b1, 1'b0);
    endtask

    task automatic test_single();
        logic [N*W-1:0] a = '0, b = '0;
        logic [N*T-1:0] tg = '0;
        a[1*W +: W] = 32'h0000_0005; b[1*W +: W] = 32'h0000_0007; tg[1*T +: T] = 6'h2A;
        tick(4'b0010, a, b, tg, 1'b1, 1'b0);
        n_checks++;
        if (obs_ready !== 4'b0010) begin
            n_fail++; $display("FAIL single_grant: got %b want 0010", obs_ready);
        end
        n_checks++;
        if ({bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src} !== {1'b1, 32'h0000_000C, 6'h2A, 2'd1}) begin
            n_fail++; $display("FAIL single_result: got v=%b sum=%h tag=%h src=%0d want v=1 sum=0000000c tag=2a src=1",
                               bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src);
        end
        tick('0, a, b, tg, 1'b1, 1'b0);
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got res_valid=%b want 0", bus.res_valid);
        end
    endtask

    task automatic test_wrap();
        logic [N*W-1:0] a = '0, b = '0;
        logic [N*T-1:0] tg = '0;
        a[2*W +: W] = 32'hFFFF_FFFF; b[2*W +: W] = 32'h0000_0002; tg[2*T +: T] = 6'h11;
        tick(4'b0100, a, b, tg, 1'b1, 1'b0);
        n_checks++;
        if ({bus.res_valid, bus.res_sum, bus.res_src} !== {1'b1, 32'h0000_0001, 2'd2}) begin
            n_fail++; $display("FAIL wrap_sum: got v=%b sum=%h src=%0d want v=1 sum=00000001 src=2",
                               bus.res_valid, bus.res_sum, bus.res_src);
        end
        tick('0, a, b, tg, 1'b1, 1'b0);
    endtask

    task automatic test_back_pressure();
        logic [N*W-1:0] a = '0, b = '0;
        logic [N*T-1:0] tg = '0;
        logic [W-1:0]   sum_a;
        a[0 +: W] = 32'h1234_0000; b[0 +: W] = 32'h0000_5678; tg[0 +: T] = 6'h05;
        sum_a = 32'h1234_5678;
        tick(4'b0001, a, b, tg, 1'b1, 1'b0);
        a[0 +: W] = 32'h8000_0000; b[0 +: W] = 32'h8000_0003; tg[0 +: T] = 6'h3C;
        for (int i = 0; i < 3; i++) begin
            tick(4'b0001, a, b, tg, 1'b0, 1'b0);
            n_checks++;
            if (obs_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, obs_ready);
            end
            n_checks++;
            if ({bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src} !== {1'b1, sum_a, 6'h05, 2'd0}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b sum=%h tag=%h want v=1 sum=%h tag=05",
                                   i, bus.res_valid, bus.res_sum, bus.res_tag, sum_a);
            end
        end
        tick(4'b0001, a, b, tg, 1'b1, 1'b0);
        n_checks++;
        if (obs_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_release_grant: got %b want 0001", obs_ready);
        end
        n_checks++;
        if ({bus.res_valid, bus.res_sum, bus.res_tag} !== {1'b1, 32'h0000_0003, 6'h3C}) begin
            n_fail++; $display("FAIL bp_release_result: got v=%b sum=%h tag=%h want v=1 sum=00000003 tag=3c",
                               bus.res_valid, bus.res_sum, bus.res_tag);
        end
        tick('0, a, b, tg, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        logic [N*W-1:0] a, b;
        logic [N*T-1:0] tg;
        for (int r = 0; r < N; r++) begin
            a[r*W +: W] = $urandom; b[r*W +: W] = $urandom; tg[r*T +: T] = T'($urandom);
        end
        tick(4'b0001, a, b, tg, 1'b1, 1'b0);
        tick(4'b0100, a, b, tg, 1'b0, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0000) begin
            n_fail++; $display("FAIL flush_ready: got %b want 0000", obs_ready);
        end
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid: got %b want 0", bus.res_valid);
        end
        // Pointer sits at 1 after the grant to requester 0; flush must not move it
        tick(4'b0101, a, b, tg, 1'b1, 1'b0);
        n_checks++;
        if (obs_ready !== 4'b0100 || obs_ready !== exp_ready) begin
            n_fail++; $display("FAIL flush_ptr: got %b want 0100", obs_ready);
        end
        n_checks++;
        if ({bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src} !== {m_valid, m_sum, m_tag, m_src}) begin
            n_fail++; $display("FAIL flush_after: got v=%b sum=%h tag=%h src=%0d want v=%b sum=%h tag=%h src=%0d",
                               bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src, m_valid, m_sum, m_tag, m_src);
        end
        tick('0, a, b, tg, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [N*W-1:0] a, b;
        logic [N*T-1:0] tg;
        for (int r = 0; r < N; r++) begin
            a[r*W +: W] = $urandom | 32'h1; b[r*W +: W] = $urandom; tg[r*T +: T] = T'($urandom) | 6'h1;
        end
        tick(4'b0110, a, b, tg, 1'b1, 1'b0);
        n_checks++;
        if (bus.res_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got res_valid=%b want 1", bus.res_valid);
        end
        bus.req_valid = 4'b1111; bus.res_ready = 1'b0;
        #2 rst_aL = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 0000", bus.req_ready);
        end
        n_checks++;
        if ({bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src} !== '0) begin
            n_fail++; $display("FAIL rstmid_result: got v=%b sum=%h tag=%h src=%0d want all zero",
                               bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src);
        end
`ifdef SHARED_ADDER_ARB_PERF_EN
        n_checks++;
        if (perf_conflict_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_perf: got %0d want 0", perf_conflict_cnt);
        end
`endif
        bus.req_valid = '0;
        @(negedge clk); rst_aL = 1'b1;
        model_reset();
        @(posedge clk); #1;
        tick(4'b1111, a, b, tg, 1'b1, 1'b0);
        n_checks++;
        if (obs_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_ptr: got %b want 0001", obs_ready);
        end
        tick('0, a, b, tg, 1'b1, 1'b0);
    endtask

`ifdef SHARED_ADDER_ARB_PERF_EN
    task automatic test_perf();
        logic [N*W-1:0] a, b;
        logic [N*T-1:0] tg;
        logic [31:0]    base;
        base = perf_conflict_cnt;
        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < N; r++) begin
                a[r*W +: W] = $urandom; b[r*W +: W] = $urandom; tg[r*T +: T] = T'($urandom);
            end
            tick(4'b0011, a, b, tg, 1'b1, 1'b0);
        end
        // Back-pressured cycle with two valids: no transfer, no count
        tick(4'b0011, a, b, tg, 1'b0, 1'b0);
        n_checks++;
        if (perf_conflict_cnt - base !== 32'd5 || perf_conflict_cnt !== 32'(m_perf)) begin
            n_fail++; $display("FAIL perf_count: got %0d (delta %0d) want %0d (delta 5)",
                               perf_conflict_cnt, perf_conflict_cnt - base, m_perf);
        end
        tick('0, a, b, tg, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic [N-1:0]   pv = '0;
        logic [N*W-1:0] pa = '0, pb = '0;
        logic [N*T-1:0] pt = '0;
        logic           rr, fl;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < N; r++) begin
                if (!pv[r] && $urandom_range(0, 1) == 1) begin
                    pv[r] = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       pa[r*W +: W] = 32'hFFFF_FFFF;
                        1:       pa[r*W +: W] = 32'h0;
                        default: pa[r*W +: W] = $urandom;
                    endcase
                    pb[r*W +: W] = $urandom;
                    pt[r*T +: T] = T'($urandom);
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 15) == 0);
            tick(pv, pa, pb, pt, rr, fl);
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_grant[%0d]: got %b want %b", cyc, obs_ready, exp_ready);
            end
            n_checks++;
            if (bus.res_valid !== m_valid ||
                (m_valid && {bus.res_sum, bus.res_tag, bus.res_src} !== {m_sum, m_tag, m_src})) begin
                n_fail++; $display("FAIL rand_result[%0d]: got v=%b sum=%h tag=%h src=%0d want v=%b sum=%h tag=%h src=%0d",
                                   cyc, bus.res_valid, bus.res_sum, bus.res_tag, bus.res_src, m_valid, m_sum, m_tag, m_src);
            end
            pv = pv & ~exp_ready;
        end
`ifdef SHARED_ADDER_ARB_PERF_EN
        n_checks++;
        if (perf_conflict_cnt !== 32'(m_perf)) begin
            n_fail++; $display("FAIL rand_perf: got %0d want %0d", perf_conflict_cnt, m_perf);
        end
`endif
        tick('0, pa, pb, pt, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_back_pressure();
        test_flush();
        test_reset_mid();
`ifdef SHARED_ADDER_ARB_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shared_adder_arbiter.md
# shared_adder_arbiter

Round-robin arbiter that shares one WIDTH-bit ripple-carry adder instance among N_REQ requesters, such as the AGU, branch-target and PC+4 paths of the OOO core. Each requester presents its operands with a valid/ready handshake. One request is granted per cycle and passed through the adder. The sum is registered with the requester's tag and source index and presented on a single valid/ready result port.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/sum width in bits (≥2)
- TAG_WIDTH, 6, opaque tag width (ROB id) carried alongside each request
- SRC_WIDTH, $clog2(N_REQ), width of the source-index field
- clk  input  1  core clock, all state on rising edge
- rst_aL  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous pipeline flush
- req_valid  input  N_REQ  requester i has an operand pair
- req_ready  output  N_REQ  requester i granted this cycle (one-hot or zero)
- req_a  input  N_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  operand B, same packing
- req_tag  input  N_REQ*TAG_WIDTH  tag; requester i at [i*TAG_WIDTH +: TAG_WIDTH]
- res_valid  output  1  result register holds a result
- res_ready  input  1  consumer accepts result
- res_sum  output  WIDTH  (a+b) mod 2^WIDTH
- res_tag  output  TAG_WIDTH  tag of the granted request
- res_src  output  SRC_WIDTH  index of the granted requester

## Operation
- State:
  - result register: res_valid, res_sum, res_tag, res_src
  - round-robin pointer rr_ptr (SRC_WIDTH bits, range 0..N_REQ-1)
- out_free = !res_valid || res_ready.
- Grant:
  - When out_free && !flush, grant the first requester with req_valid set, scanning rr_ptr, rr_ptr+1, … mod N_REQ.
  - req_ready is the one-hot grant vector and is all-zero otherwise.
  - A transfer occurs when req_valid[i] && req_ready[i].
- Adder: a single adder instance, combinational. Its inputs are muxed from the granted requester. The carry-out is discarded, so the sum wraps modulo 2^WIDTH.
- On transfer from requester g:
  - res_sum ← sum, res_tag ← req_tag[g], res_src ← g, res_valid ← 1.
  - rr_ptr ← (g+1) mod N_REQ.
- No transfer, with res_valid && res_ready: res_valid ← 0. Data fields hold their last value.
- No transfer, with res_valid && !res_ready: the result register holds all fields.
- Simultaneous drain and grant in one cycle: the new result replaces the old one and res_valid stays 1. Full throughput is one result per cycle.
- rr_ptr changes only on a transfer. An idle cycle or a back-pressured cycle leaves it unchanged.
- flush:
  - req_ready is forced to 0.
  - Next cycle res_valid = 0.
  - rr_ptr is unchanged. Data fields are don't-care.
- Requesters may not drop req_valid or change operands while valid and not yet granted. The block does not check this.

## Timing
- Reset (rst_aL low, asynchronous):
  - res_valid=0, res_sum=0, res_tag=0, res_src=0, rr_ptr=0.
  - req_ready=0 while reset is asserted.
- Latency is 1 cycle: a transfer on edge n gives res_valid=1 with the sum in the cycle after edge n.
- req_ready is combinational from req_valid, res_valid, res_ready, flush and rr_ptr. No path exists from req_a/req_b to req_ready.
- The critical path is operand mux → ripple adder → res_sum flop.
- Reset asserted mid-operation discards any held result. No partial state survives.
- Fairness: a continuously valid requester is granted within N_REQ transfers.

## Configuration
- SHARED_ADDER_ARB_PERF_EN defined:
  - Adds output perf_conflict_cnt[31:0].
  - The counter increments each cycle in which ≥2 bits of req_valid are set and a transfer occurs.
  - It saturates at 0xFFFF_FFFF.
  - It resets to 0 on rst_aL and is not cleared by flush.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset: drive rst_aL low mid-run with res_valid=1 → res_valid=0, res_sum=0, rr_ptr=0, and req_ready=0 asynchronously.
- Single requester: req_valid=4'b0010, a=0x0000_0005, b=0x0000_0007, tag=0x2A, res_ready=1 → next cycle res_valid=1, res_sum=0x0000_000C, res_tag=0x2A, res_src=1.
- Wrap-around: a=0xFFFF_FFFF, b=0x0000_0002 → res_sum=0x0000_0001.
- Round-robin: req_valid=4'b1111 held for 8 cycles with res_ready=1 → grant order 0,1,2,3,0,1,2,3, one result per cycle, and rr_ptr back at 0.
- Back-pressure: res_valid=1 with res_ready=0 for 3 cycles while req_valid=4'b0001 → req_ready=0 and the result is held stable. When res_ready returns to 1, the new grant and drain happen in the same cycle and res_valid stays 1.
- Flush: flush=1 with res_valid=1 and req_valid=4'b0100 → req_ready=0 and res_valid=0 next cycle. With PERF_EN, two simultaneous valids over 5 transfers give perf_conflict_cnt=5.
